// File: rtl/counter_bank.sv
// Bank of NCH independent up/down counters, each with a prescaler, wrap/saturate and event pulses.
// Define COUNTER_BANK_CAPTURE_EN to add the capture input and the capt_count snapshot register.
module counter_bank #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 24
) (
  input  logic                   sys_clk,
  input  logic                   reset_n,
  input  logic [NCH-1:0]         ch_enable,
  input  logic [NCH-1:0]         ch_clear,
  input  logic [NCH-1:0]         ch_up,
  input  logic [NCH-1:0]         ch_down,
  input  logic [NCH-1:0]         ch_auto,
  input  logic [NCH-1:0]         ch_dir,
  input  logic [NCH-1:0]         ch_wrap,
  input  logic [NCH*DIV_W-1:0]   div_reload,
  input  logic [NCH*WIDTH-1:0]   cmp_value,
`ifdef COUNTER_BANK_CAPTURE_EN
  input  logic                   capture,
  output logic [NCH*WIDTH-1:0]   capt_count,
`endif
  output logic [NCH*WIDTH-1:0]   count,
  output logic [NCH-1:0]         eq_zero,
  output logic [NCH-1:0]         eq_cmp,
  output logic [NCH-1:0]         tc
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [WIDTH-1:0] MaxVal = '1;

    logic [DIV_W-1:0] r_presc;
    logic [DIV_W-1:0] w_presc_d;
    logic             w_tick;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_d;
    logic [WIDTH-1:0] w_cmp;
    logic             w_inc;
    logic             w_dec;
    logic             w_tc_d;
    logic             r_tc;
    logic             r_eq_zero;
    logic             r_eq_cmp;
    // Edge history stores "not equal", so its reset value of 0 means "was equal".
    logic             r_zero_ne;
    logic             r_cmp_ne;

    assign w_cmp = cmp_value[i*WIDTH +: WIDTH];

    always_comb begin
      w_tick    = ch_enable[i] && (r_presc == '0);
      w_presc_d = r_presc;
      if (ch_enable[i]) begin
        w_presc_d = w_tick ? div_reload[i*DIV_W +: DIV_W] : r_presc - DIV_W'(1);
      end
    end

    always_comb begin
      w_inc     = 1'b0;
      w_dec     = 1'b0;
      w_tc_d    = 1'b0;
      w_count_d = r_count;
      if (ch_clear[i]) begin
        w_count_d = '0;
      end else if (ch_enable[i]) begin
        if (ch_up[i]) begin
          w_inc = 1'b1;
        end else if (ch_down[i]) begin
          w_dec = 1'b1;
        end else if (ch_auto[i] && w_tick) begin
          w_inc = !ch_dir[i];
          w_dec = ch_dir[i];
        end
      end
      if (w_inc) begin
        if (r_count == MaxVal) begin
          w_tc_d    = 1'b1;
          w_count_d = ch_wrap[i] ? '0 : r_count;
        end else begin
          w_count_d = r_count + WIDTH'(1);
        end
      end else if (w_dec) begin
        if (r_count == '0) begin
          w_tc_d    = 1'b1;
          w_count_d = ch_wrap[i] ? MaxVal : r_count;
        end else begin
          w_count_d = r_count - WIDTH'(1);
        end
      end
    end

    always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
        r_presc   <= '0;
        r_count   <= '0;
        r_tc      <= 1'b0;
        r_eq_zero <= 1'b0;
        r_eq_cmp  <= 1'b0;
        r_zero_ne <= 1'b0;
        r_cmp_ne  <= 1'b0;
      end else begin
        r_presc   <= w_presc_d;
        r_count   <= w_count_d;
        r_tc      <= w_tc_d;
        // Entry-edge detection on the registered count; a cmp_value change counts as an entry.
        r_eq_zero <= (r_count == '0) && r_zero_ne;
        r_eq_cmp  <= (r_count == w_cmp) && r_cmp_ne;
        r_zero_ne <= (r_count != '0);
        r_cmp_ne  <= (r_count != w_cmp);
      end
    end

    assign count[i*WIDTH +: WIDTH] = r_count;
    assign eq_zero[i]              = r_eq_zero;
    assign eq_cmp[i]               = r_eq_cmp;
    assign tc[i]                   = r_tc;
  end

`ifdef COUNTER_BANK_CAPTURE_EN
  logic [NCH*WIDTH-1:0] r_capt;

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_capt <= '0;
    end else if (capture) begin
      r_capt <= count;
    end
  end

  assign capt_count = r_capt;
`endif

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank (NCH=2, WIDTH=8): vector table plus multi-cycle sequences.
// Capture checks are built only when COUNTER_BANK_CAPTURE_EN is defined.
module tb_counter_bank;
  localparam int unsigned NCH   = 2;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIV_W = 24;

  logic                 sys_clk = 1'b0;
  logic                 reset_n;
  logic [NCH-1:0]       ch_enable, ch_clear, ch_up, ch_down, ch_auto, ch_dir, ch_wrap;
  logic [NCH*DIV_W-1:0] div_reload;
  logic [NCH*WIDTH-1:0] cmp_value;
  logic [NCH*WIDTH-1:0] count;
  logic [NCH-1:0]       eq_zero, eq_cmp, tc;
`ifdef COUNTER_BANK_CAPTURE_EN
  logic                 capture;
  logic [NCH*WIDTH-1:0] capt_count;
`endif

  counter_bank #(
    .NCH  (NCH),
    .WIDTH(WIDTH),
    .DIV_W(DIV_W)
  ) dut (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .ch_enable (ch_enable),
    .ch_clear  (ch_clear),
    .ch_up     (ch_up),
    .ch_down   (ch_down),
    .ch_auto   (ch_auto),
    .ch_dir    (ch_dir),
    .ch_wrap   (ch_wrap),
    .div_reload(div_reload),
    .cmp_value (cmp_value),
`ifdef COUNTER_BANK_CAPTURE_EN
    .capture   (capture),
    .capt_count(capt_count),
`endif
    .count     (count),
    .eq_zero   (eq_zero),
    .eq_cmp    (eq_cmp),
    .tc        (tc)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [21:0] exp;  // {count1, count0, eq_zero, eq_cmp, tc}
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string      name;
    logic [1:0] en, clr, up, dn, wrap;
    logic [7:0] c0, c1;
    logic [1:0] eqz, eqc, tc;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic clear_pulses();
    ch_clear = '0;
    ch_up    = '0;
    ch_down  = '0;
`ifdef COUNTER_BANK_CAPTURE_EN
    capture  = 1'b0;
`endif
  endtask

  // Push the expectation for the coming edge, then pop and compare just after it.
  task automatic cycle(input string name, input logic [7:0] c0, input logic [7:0] c1,
                       input logic [1:0] z, input logic [1:0] q, input logic [1:0] t);
    sb_t e;
    e.name = name;
    e.exp  = {c1, c0, z, q, t};
    sb_q.push_back(e);
    @(posedge sys_clk);
    #1;
    e = sb_q.pop_front();
    check(e.name, 64'({count, eq_zero, eq_cmp, tc}), 64'(e.exp));
    clear_pulses();
  endtask

  task automatic free_cycle();
    @(posedge sys_clk);
    #1;
    clear_pulses();
  endtask

  task automatic do_reset(input string name);
    reset_n = 1'b0;
    cycle(name, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    reset_n = 1'b1;
  endtask

  task automatic add(input string name, input logic [1:0] en, input logic [1:0] clr,
                     input logic [1:0] up, input logic [1:0] dn, input logic [1:0] wrap,
                     input logic [7:0] c0, input logic [7:0] c1, input logic [1:0] eqz,
                     input logic [1:0] eqc, input logic [1:0] t);
    vec_t v;
    v.name = name; v.en = en; v.clr = clr; v.up = up; v.dn = dn; v.wrap = wrap;
    v.c0 = c0; v.c1 = c1; v.eqz = eqz; v.eqc = eqc; v.tc = t;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit hit before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    ch_enable  = '0;
    ch_auto    = '0;
    ch_dir     = '0;
    ch_wrap    = '0;
    div_reload = '0;
    cmp_value  = {8'hF0, 8'h80};
    clear_pulses();

    //    name              en     clr    up     dn     wrap   c0     c1     eqz    eqc    tc
    add("idle_after_rst", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    add("up_both",        2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 8'h01, 8'h01, 2'b00, 2'b00, 2'b00);
    add("up_ch0",         2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 8'h02, 8'h01, 2'b00, 2'b00, 2'b00);
    add("down_ch1_to_0",  2'b11, 2'b00, 2'b00, 2'b10, 2'b00, 8'h02, 8'h00, 2'b00, 2'b00, 2'b00);
    add("eqz_ch1_pulse",  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 8'h02, 8'h00, 2'b10, 2'b00, 2'b00);
    add("eqz_ch1_held",   2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 8'h02, 8'h00, 2'b00, 2'b00, 2'b00);
    add("down_sat_tc",    2'b11, 2'b00, 2'b00, 2'b10, 2'b00, 8'h02, 8'h00, 2'b00, 2'b00, 2'b10);
    add("sat_no_eqz",     2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 8'h02, 8'h00, 2'b00, 2'b00, 2'b00);
    add("down_wrap_tc",   2'b11, 2'b00, 2'b00, 2'b10, 2'b10, 8'h02, 8'hFF, 2'b00, 2'b00, 2'b10);
    add("up_wrap_tc",     2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 8'h02, 8'h00, 2'b00, 2'b00, 2'b10);
    add("eqz_after_wrap", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 8'h02, 8'h00, 2'b10, 2'b00, 2'b00);
    add("up_and_down",    2'b11, 2'b00, 2'b01, 2'b01, 2'b00, 8'h03, 8'h00, 2'b00, 2'b00, 2'b00);
    add("up_to_4",        2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 8'h04, 8'h00, 2'b00, 2'b00, 2'b00);
    add("up_to_5",        2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 8'h05, 8'h00, 2'b00, 2'b00, 2'b00);
    add("clr_up_down",    2'b11, 2'b01, 2'b01, 2'b01, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    add("eqz_after_clr",  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00);
    add("eqz_once",       2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    add("dis_ch0_up",     2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 8'h00, 8'h01, 2'b00, 2'b00, 2'b00);
    add("en_ch0_up",      2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 8'h01, 8'h01, 2'b00, 2'b00, 2'b00);
    add("dis_ch0_clear",  2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 8'h01, 2'b00, 2'b00, 2'b00);
    add("eqz_dis_clear",  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h01, 2'b01, 2'b00, 2'b00);

    @(negedge sys_clk);
    do_reset("reset_init");

    foreach (vecs[n]) begin
      ch_enable = vecs[n].en;
      ch_clear  = vecs[n].clr;
      ch_up     = vecs[n].up;
      ch_down   = vecs[n].dn;
      ch_wrap   = vecs[n].wrap;
      cycle(vecs[n].name, vecs[n].c0, vecs[n].c1, vecs[n].eqz, vecs[n].eqc, vecs[n].tc);
    end

    // Reload 3: first enabled edge ticks from the reset prescaler, then every 4th edge.
    ch_enable = 2'b11;
    ch_wrap   = 2'b00;
    do_reset("reset_auto");
    div_reload = {24'd0, 24'd3};
    ch_auto    = 2'b01;
    ch_dir     = 2'b00;
    ch_wrap    = 2'b01;
    for (int k = 1; k <= 12; k++) begin
      cycle($sformatf("auto_up_%0d", k), 8'((k - 1) / 4 + 1), 8'h00, 2'b00, 2'b00, 2'b00);
    end

    // 0xFF -> 0x00 by autocount with wrap: one tc, then eq_zero.
    ch_auto   = 2'b00;
    do_reset("reset_wrap");
    ch_enable = 2'b01;
    ch_down   = 2'b01;
    cycle("wrap_down_tc", 8'hFF, 8'h00, 2'b00, 2'b00, 2'b01);
    ch_auto = 2'b01;
    for (int k = 2; k <= 4; k++) cycle("auto_hold_ff", 8'hFF, 8'h00, 2'b00, 2'b00, 2'b00);
    cycle("auto_wrap_tc", 8'h00, 8'h00, 2'b00, 2'b00, 2'b01);
    cycle("auto_wrap_eqz", 8'h00, 8'h00, 2'b01, 2'b00, 2'b00);
    cycle("auto_no_2nd_tc", 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    ch_auto = 2'b00;

    // Compare entry: one pulse, none while held, and one on a cmp_value change.
    do_reset("reset_cmp");
    ch_enable = 2'b01;
    for (int k = 0; k < 127; k++) begin
      ch_up = 2'b01;
      free_cycle();
    end
    ch_up = 2'b01;
    cycle("up_to_cmp", 8'h80, 8'h00, 2'b00, 2'b00, 2'b00);
    cycle("eq_cmp_pulse", 8'h80, 8'h00, 2'b00, 2'b01, 2'b00);
    for (int k = 0; k < 10; k++) cycle("eq_cmp_held", 8'h80, 8'h00, 2'b00, 2'b00, 2'b00);
    cmp_value[7:0] = 8'h81;
    cycle("cmp_moved", 8'h80, 8'h00, 2'b00, 2'b00, 2'b00);
    cmp_value[7:0] = 8'h80;
    cycle("cmp_back_pulse", 8'h80, 8'h00, 2'b00, 2'b01, 2'b00);
    cycle("cmp_back_once", 8'h80, 8'h00, 2'b00, 2'b00, 2'b00);

    // Channel 0 disabled with up pulses and auto; channel 1 ticks every cycle.
    do_reset("reset_indep");
    div_reload = '0;
    ch_enable  = 2'b10;
    ch_auto    = 2'b11;
    ch_wrap    = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      ch_up = 2'b01;
      cycle($sformatf("ch0_frozen_%0d", k), 8'h00, 8'(k), 2'b00, 2'b00, 2'b00);
    end
    // Reset during a boundary step attempt: no tc, everything zero.
    reset_n   = 1'b0;
    ch_enable = 2'b11;
    ch_down   = 2'b01;
    ch_dir    = 2'b00;
    cycle("reset_midrun", 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    reset_n = 1'b1;
    cycle("after_reset_tick", 8'h01, 8'h01, 2'b00, 2'b00, 2'b00);
    ch_auto = 2'b00;

`ifdef COUNTER_BANK_CAPTURE_EN
    do_reset("reset_capt");
    ch_enable = 2'b11;
    for (int k = 0; k < 8'h12; k++) begin
      ch_up = 2'b11;
      free_cycle();
    end
    for (int k = 0; k < 8'h22; k++) begin
      ch_up = 2'b10;
      free_cycle();
    end
    cycle("capt_pre", 8'h12, 8'h34, 2'b00, 2'b00, 2'b00);
    ch_auto = 2'b11;
    capture = 1'b1;
    cycle("capt_edge", 8'h13, 8'h35, 2'b00, 2'b00, 2'b00);
    check("capt_latched", 64'(capt_count), 64'(16'h3412));
    cycle("capt_live", 8'h14, 8'h36, 2'b00, 2'b00, 2'b00);
    check("capt_held", 64'(capt_count), 64'(16'h3412));
    ch_auto = 2'b00;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 SHALL have parameter NCH, default 2: number of independent counter channels, 1..16.
REQ-002 SHALL have parameter WIDTH, default 8: counter width per channel, 2..32.
REQ-003 SHALL have parameter DIV_W, default 24: prescaler width per channel.
REQ-004 sys_clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 ch_enable  in  NCH  level; 0 freezes the channel's prescaler and counter (clear still acts).
REQ-007 ch_clear  in  NCH  one-cycle pulse; count to 0.
REQ-008 ch_up / ch_down  in  NCH each  one-cycle pulses; manual step +1 / -1.
REQ-009 ch_auto  in  NCH  level; prescaler ticks step the counter.
REQ-010 ch_dir  in  NCH  autocount direction: 0 up, 1 down.
REQ-011 ch_wrap  in  NCH  1 wrap-around, 0 saturate at 0 / 2^WIDTH-1.
REQ-012 div_reload  in  NCH*DIV_W  per-channel prescaler reload, channel i at [i*DIV_W +: DIV_W].
REQ-013 cmp_value  in  NCH*WIDTH  per-channel compare value.
REQ-014 count  out  NCH*WIDTH  registered counter values.
REQ-015 eq_zero / eq_cmp / tc  out  NCH each  one-cycle event pulses.

Function
REQ-016 Prescaler SHALL decrement each enabled cycle; at 0 it SHALL reload div_reload and assert the internal tick for exactly one cycle; reload 0 SHALL tick every enabled cycle.
REQ-017 A div_reload change SHALL take effect at the next reload only.
REQ-018 Count update priority SHALL be: clear > up > down > (ch_auto & tick, direction per ch_dir); at most one step per cycle; up and down together SHALL step +1.
REQ-019 count SHALL reflect an accepted step on the cycle after the stimulus (latency 1).
REQ-020 Up at 2^WIDTH-1 SHALL go to 0 if ch_wrap=1, else hold; down at 0 SHALL go to 2^WIDTH-1 if ch_wrap=1, else hold.
REQ-021 tc SHALL pulse one cycle after any step attempted at a boundary per REQ-020, wrapped or saturated.
REQ-022 eq_zero / eq_cmp SHALL pulse one cycle after count newly becomes equal to 0 / cmp_value (entry edge only, not while held).
REQ-023 A cmp_value change making an unchanged count equal SHALL also produce one eq_cmp pulse.
REQ-024 ch_enable=0 SHALL ignore up/down/tick and hold the prescaler; ch_clear SHALL still clear the count.
REQ-025 Channels SHALL be fully independent; no cross-channel interaction.

Reset
REQ-026 reset_n=0 at a clock edge SHALL set every count, prescaler, and edge-history register to 0 and force eq_zero, eq_cmp, tc, and capt_count to 0 that cycle.
REQ-027 After reset is released, eq_zero SHALL NOT pulse for the count reset to 0; the edge history SHALL initialise as "equal to 0".
REQ-028 Reset asserted mid-count SHALL abort any pending step; no tc SHALL be generated.

Configuration
REQ-029 With macro COUNTER_BANK_CAPTURE_EN defined: port capture (in 1) and capt_count (out NCH*WIDTH) SHALL exist; a capture pulse SHALL latch all count values simultaneously into capt_count on the next cycle.
REQ-030 Without COUNTER_BANK_CAPTURE_EN: both ports and the latch logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 NCH=2, WIDTH=8: reload=3, auto=1, dir=0 -> count +1 every 4 cycles; 0xFF->0x00 with wrap=1 and one tc pulse.
REQ-032 Channel at 0x00, wrap=0, ch_down pulse -> count stays 0x00; tc pulses once; eq_zero does not pulse.
REQ-033 ch_clear, ch_up, and ch_down in the same cycle at count 0x05 -> count 0x00 next cycle; eq_zero pulses once.
REQ-034 cmp_value=0x80, count 0x7F, ch_up -> count 0x80; eq_cmp exactly one pulse; a further 10 idle cycles produce no pulse.
REQ-035 ch_enable=0 with ch_up pulses and auto ticks on channel 0 -> channel 0 holds and channel 1 is unaffected; reset_n low mid-run -> all outputs 0 the next cycle.
REQ-036 With COUNTER_BANK_CAPTURE_EN: counts 0x12/0x34, capture pulse -> capt_count = {0x34,0x12} while the live counts keep advancing.
